// File: rtl/ob_book_table.sv
// ob_book_table
// Sorted price-time-priority order table for one book side. Slots 0..count-1
// hold the valid entries in priority order, and slot 0 is the best price.
// Commands are accepted one per cycle. The table, head, count and reject
// slot all change at the next edge, and a one-cycle response pulse
// describes the entry the command affected.
//
// Parameters: N (depth), IS_ASK (1 = lowest price first, 0 = highest first),
//             PRICE_W, QTY_W, UID_W (field widths).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy                  command handshake
//   cmd_op                           0 INSERT, 1 CANCEL, 2 POP_HEAD, 3 FILL_HEAD, 4 MODIFY
//   cmd_uid/cmd_price/cmd_qty        command operands
//   rsp_vld/rsp_hit/rsp_uid/rsp_price/rsp_qty  response pulse and affected entry
//   head_*_r                         registered best entry
//   count_r/full_r                   occupancy
//   reject_*_r, reject_pop           displaced/rejected entry and its consume strobe
// Optional build macro: OB_BOOK_TABLE_MODIFY_EN enables op 4 (MODIFY).
// Without the macro, op 4 is treated as an illegal op.
module ob_book_table #(
    parameter int N       = 16,
    parameter int IS_ASK  = 1,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16,
    parameter int UID_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [2:0]               cmd_op,
    input  logic [UID_W-1:0]         cmd_uid,
    input  logic [PRICE_W-1:0]       cmd_price,
    input  logic [QTY_W-1:0]         cmd_qty,
    output logic                     rsp_vld,
    output logic                     rsp_hit,
    output logic [UID_W-1:0]         rsp_uid,
    output logic [PRICE_W-1:0]       rsp_price,
    output logic [QTY_W-1:0]         rsp_qty,
    output logic                     head_vld_r,
    output logic [UID_W-1:0]         head_uid_r,
    output logic [PRICE_W-1:0]       head_price_r,
    output logic [QTY_W-1:0]         head_qty_r,
    output logic [$clog2(N+1)-1:0]   count_r,
    output logic                     full_r,
    output logic                     reject_vld_r,
    output logic [UID_W-1:0]         reject_uid_r,
    output logic [PRICE_W-1:0]       reject_price_r,
    output logic [QTY_W-1:0]         reject_qty_r,
    input  logic                     reject_pop
);
    localparam int CW = $clog2(N+1);
    localparam logic [2:0] OP_INSERT = 3'd0;
    localparam logic [2:0] OP_CANCEL = 3'd1;
    localparam logic [2:0] OP_POP    = 3'd2;
    localparam logic [2:0] OP_FILL   = 3'd3;
`ifdef OB_BOOK_TABLE_MODIFY_EN
    localparam logic [2:0] OP_MODIFY = 3'd4;
`endif

    logic [UID_W-1:0]   uid_reg [N];
    logic [UID_W-1:0]   uid_next [N];
    logic [PRICE_W-1:0] price_reg [N];
    logic [PRICE_W-1:0] price_next [N];
    logic [QTY_W-1:0]   qty_reg [N];
    logic [QTY_W-1:0]   qty_next [N];
    // Neighbour views used for the one-slot shifts. Zeros shift in at the
    // tail so slots beyond count always read as zero.
    logic [UID_W-1:0]   uid_prev [N];
    logic [UID_W-1:0]   uid_succ [N];
    logic [PRICE_W-1:0] price_prev [N];
    logic [PRICE_W-1:0] price_succ [N];
    logic [QTY_W-1:0]   qty_prev [N];
    logic [QTY_W-1:0]   qty_succ [N];

    logic [CW-1:0] count_reg, count_next;
    logic [N-1:0]  slot_valid, slot_better, slot_match;
    logic [N-1:0]  at_ins, after_ins, from_rm, at_set;

    logic               acc, full;
    logic [CW-1:0]      ins_pos, rm_idx, set_idx, match_idx;
    logic               ins_en, rm_en, set_en;
    logic [QTY_W-1:0]   set_val;
    logic [UID_W-1:0]   match_uid;
    logic [PRICE_W-1:0] match_price;
    logic [QTY_W-1:0]   match_qty;

    logic               rsp_vld_reg, rsp_hit_reg, rsp_hit_next;
    logic [UID_W-1:0]   rsp_uid_reg, rsp_uid_next;
    logic [PRICE_W-1:0] rsp_price_reg, rsp_price_next;
    logic [QTY_W-1:0]   rsp_qty_reg, rsp_qty_next;

    logic               rej_new;
    logic [UID_W-1:0]   rej_uid;
    logic [PRICE_W-1:0] rej_price;
    logic [QTY_W-1:0]   rej_qty;
    logic               reject_vld_reg, reject_vld_next;
    logic [UID_W-1:0]   reject_uid_reg, reject_uid_next;
    logic [PRICE_W-1:0] reject_price_reg, reject_price_next;
    logic [QTY_W-1:0]   reject_qty_reg, reject_qty_next;

    assign full    = (count_reg == CW'(N));
    assign cmd_rdy = !reject_vld_reg | reject_pop;
    assign acc     = cmd_vld & cmd_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign slot_valid[gi] = (CW'(gi) < count_reg);
            // "Better or equal" marks the entries a new order must queue behind.
            if (IS_ASK != 0) begin : g_ask
                assign slot_better[gi] = slot_valid[gi] && (price_reg[gi] <= cmd_price);
            end else begin : g_bid
                assign slot_better[gi] = slot_valid[gi] && (price_reg[gi] >= cmd_price);
            end
            assign slot_match[gi] = slot_valid[gi] && (uid_reg[gi] == cmd_uid);
            assign at_ins[gi]     = (CW'(gi) == ins_pos);
            assign after_ins[gi]  = (CW'(gi) > ins_pos);
            assign from_rm[gi]    = (CW'(gi) >= rm_idx);
            assign at_set[gi]     = (CW'(gi) == set_idx);
            if (gi == 0) begin : g_first
                assign uid_prev[gi]   = '0;
                assign price_prev[gi] = '0;
                assign qty_prev[gi]   = '0;
            end else begin : g_mid_prev
                assign uid_prev[gi]   = uid_reg[gi-1];
                assign price_prev[gi] = price_reg[gi-1];
                assign qty_prev[gi]   = qty_reg[gi-1];
            end
            if (gi == N-1) begin : g_last
                assign uid_succ[gi]   = '0;
                assign price_succ[gi] = '0;
                assign qty_succ[gi]   = '0;
            end else begin : g_mid_succ
                assign uid_succ[gi]   = uid_reg[gi+1];
                assign price_succ[gi] = price_reg[gi+1];
                assign qty_succ[gi]   = qty_reg[gi+1];
            end
        end
    endgenerate

    // Because the table is sorted, the better-or-equal entries form a prefix,
    // so the insert slot is simply how many of them there are.
    always_comb begin
        ins_pos     = '0;
        match_idx   = '0;
        match_uid   = '0;
        match_price = '0;
        match_qty   = '0;
        for (int i = 0; i < N; i++) begin
            if (slot_better[i]) ins_pos = ins_pos + CW'(1);
            if (slot_match[i]) begin
                match_idx   = CW'(i);
                match_uid   = uid_reg[i];
                match_price = price_reg[i];
                match_qty   = qty_reg[i];
            end
        end
    end

    // Command decode: choose one table edit (insert, remove, or qty write),
    // the response fields, and any entry that leaves through the reject slot.
    always_comb begin
        ins_en         = 1'b0;
        rm_en          = 1'b0;
        rm_idx         = '0;
        set_en         = 1'b0;
        set_idx        = '0;
        set_val        = '0;
        rej_new        = 1'b0;
        rej_uid        = '0;
        rej_price      = '0;
        rej_qty        = '0;
        rsp_hit_next   = 1'b0;
        rsp_uid_next   = '0;
        rsp_price_next = '0;
        rsp_qty_next   = '0;
        if (acc) begin
            case (cmd_op)
                OP_INSERT: begin
                    rsp_uid_next   = cmd_uid;
                    rsp_price_next = cmd_price;
                    rsp_qty_next   = cmd_qty;
                    if (!full) begin
                        ins_en       = 1'b1;
                        rsp_hit_next = 1'b1;
                    end else if (ins_pos != CW'(N)) begin
                        // Strictly better than the tail: the tail is displaced.
                        ins_en       = 1'b1;
                        rsp_hit_next = 1'b1;
                        rej_new      = 1'b1;
                        rej_uid      = uid_reg[N-1];
                        rej_price    = price_reg[N-1];
                        rej_qty      = qty_reg[N-1];
                    end else begin
                        rej_new   = 1'b1;
                        rej_uid   = cmd_uid;
                        rej_price = cmd_price;
                        rej_qty   = cmd_qty;
                    end
                end
                OP_CANCEL: begin
                    if (|slot_match) begin
                        rm_en          = 1'b1;
                        rm_idx         = match_idx;
                        rsp_hit_next   = 1'b1;
                        rsp_uid_next   = match_uid;
                        rsp_price_next = match_price;
                        rsp_qty_next   = match_qty;
                    end
                end
                OP_POP: begin
                    if (slot_valid[0]) begin
                        rm_en          = 1'b1;
                        rsp_hit_next   = 1'b1;
                        rsp_uid_next   = uid_reg[0];
                        rsp_price_next = price_reg[0];
                        rsp_qty_next   = qty_reg[0];
                    end
                end
                OP_FILL: begin
                    if (slot_valid[0]) begin
                        rsp_hit_next   = 1'b1;
                        rsp_uid_next   = uid_reg[0];
                        rsp_price_next = price_reg[0];
                        if (cmd_qty < qty_reg[0]) begin
                            set_en  = 1'b1;
                            set_val = qty_reg[0] - cmd_qty;
                        end else begin
                            rm_en        = 1'b1;
                            rsp_qty_next = cmd_qty - qty_reg[0];
                        end
                    end else begin
                        rsp_qty_next = cmd_qty;
                    end
                end
`ifdef OB_BOOK_TABLE_MODIFY_EN
                OP_MODIFY: begin
                    if (|slot_match) begin
                        rsp_hit_next   = 1'b1;
                        rsp_uid_next   = match_uid;
                        rsp_price_next = match_price;
                        rsp_qty_next   = match_qty;
                        if (cmd_qty == '0) begin
                            rm_en  = 1'b1;
                            rm_idx = match_idx;
                        end else begin
                            set_en  = 1'b1;
                            set_idx = match_idx;
                            set_val = cmd_qty;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        count_next = count_reg;
        for (int i = 0; i < N; i++) begin
            uid_next[i]   = uid_reg[i];
            price_next[i] = price_reg[i];
            qty_next[i]   = qty_reg[i];
            if (ins_en) begin
                if (at_ins[i]) begin
                    uid_next[i]   = cmd_uid;
                    price_next[i] = cmd_price;
                    qty_next[i]   = cmd_qty;
                end else if (after_ins[i]) begin
                    uid_next[i]   = uid_prev[i];
                    price_next[i] = price_prev[i];
                    qty_next[i]   = qty_prev[i];
                end
            end else if (rm_en) begin
                if (from_rm[i]) begin
                    uid_next[i]   = uid_succ[i];
                    price_next[i] = price_succ[i];
                    qty_next[i]   = qty_succ[i];
                end
            end else if (set_en && at_set[i]) begin
                qty_next[i] = set_val;
            end
        end
        if (ins_en && !full) count_next = count_reg + CW'(1);
        else if (rm_en)      count_next = count_reg - CW'(1);
    end

    // A new reject overrides a simultaneous pop so the slot stays occupied.
    always_comb begin
        reject_vld_next   = reject_vld_reg;
        reject_uid_next   = reject_uid_reg;
        reject_price_next = reject_price_reg;
        reject_qty_next   = reject_qty_reg;
        if (reject_pop) reject_vld_next = 1'b0;
        if (rej_new) begin
            reject_vld_next   = 1'b1;
            reject_uid_next   = rej_uid;
            reject_price_next = rej_price;
            reject_qty_next   = rej_qty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                uid_reg[i]   <= '0;
                price_reg[i] <= '0;
                qty_reg[i]   <= '0;
            end
            count_reg        <= '0;
            rsp_vld_reg      <= 1'b0;
            rsp_hit_reg      <= 1'b0;
            rsp_uid_reg      <= '0;
            rsp_price_reg    <= '0;
            rsp_qty_reg      <= '0;
            reject_vld_reg   <= 1'b0;
            reject_uid_reg   <= '0;
            reject_price_reg <= '0;
            reject_qty_reg   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                uid_reg[i]   <= uid_next[i];
                price_reg[i] <= price_next[i];
                qty_reg[i]   <= qty_next[i];
            end
            count_reg        <= count_next;
            rsp_vld_reg      <= acc;
            rsp_hit_reg      <= rsp_hit_next;
            rsp_uid_reg      <= rsp_uid_next;
            rsp_price_reg    <= rsp_price_next;
            rsp_qty_reg      <= rsp_qty_next;
            reject_vld_reg   <= reject_vld_next;
            reject_uid_reg   <= reject_uid_next;
            reject_price_reg <= reject_price_next;
            reject_qty_reg   <= reject_qty_next;
        end
    end

    assign rsp_vld        = rsp_vld_reg;
    assign rsp_hit        = rsp_hit_reg;
    assign rsp_uid        = rsp_uid_reg;
    assign rsp_price      = rsp_price_reg;
    assign rsp_qty        = rsp_qty_reg;
    assign head_vld_r     = (count_reg != '0);
    assign head_uid_r     = uid_reg[0];
    assign head_price_r   = price_reg[0];
    assign head_qty_r     = qty_reg[0];
    assign count_r        = count_reg;
    assign full_r         = full;
    assign reject_vld_r   = reject_vld_reg;
    assign reject_uid_r   = reject_uid_reg;
    assign reject_price_r = reject_price_reg;
    assign reject_qty_r   = reject_qty_reg;
endmodule

// File: doc/ob_book_table.md
Name: ob_book_table

Overview:
- Parametrised successor to the single-side price table: a sorted, price-time-priority order table for one book side (bid or ask).
- Holds up to N resting orders with quantity. Serialises insert / cancel / pop / fill commands through a valid-ready handshake and returns a per-command response.
- A full table displaces the worst entry into a held reject slot.
- Sits between the order-entry controller and the matching engine. The head entry is the current best bid or best ask.

Parameters:
- N, 16, table depth (number of resting entries, ≥2).
- IS_ASK, 1, 1 = ask side (lowest price at head); 0 = bid side (highest price at head).
- PRICE_W, 16, packed-BCD price width; compared as unsigned binary.
- QTY_W, 16, quantity width.
- UID_W, 32, order UID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command ready; a command is accepted when cmd_vld & cmd_rdy.
- cmd_op  in  3  0 INSERT, 1 CANCEL, 2 POP_HEAD, 3 FILL_HEAD, 4 MODIFY (optional), others illegal.
- cmd_uid  in  UID_W  order UID.
- cmd_price  in  PRICE_W  insert price.
- cmd_qty  in  QTY_W  insert qty / fill qty / modify qty.
- rsp_vld  out  1  one-cycle response pulse.
- rsp_hit  out  1  command found its target.
- rsp_uid / rsp_price / rsp_qty  out  UID_W/PRICE_W/QTY_W  affected entry.
- head_vld_r  out  1  head entry valid.
- head_uid_r / head_price_r / head_qty_r  out  UID_W/PRICE_W/QTY_W  registered head.
- count_r  out  $clog2(N+1)  occupied entries.
- full_r  out  1  count_r == N.
- reject_vld_r  out  1  reject slot occupied.
- reject_uid_r / reject_price_r / reject_qty_r  out  widths as above  rejected entry.
- reject_pop  in  1  controller consumes the reject slot.

Behaviour:
- Reset (async, rst_n low): all entries invalid; count_r = 0; head_vld_r = 0; reject_vld_r = 0; rsp_vld = 0; all data outputs 0.
- cmd_rdy = !reject_vld_r | reject_pop. Acceptance stalls while an unconsumed reject is held.
- Latency: a command accepted in cycle t updates the table, head, count and reject at the t+1 edge. rsp_vld is asserted in cycle t+1 with fields sampled from the pre-update state (CANCEL/POP/FILL) or the inserted entry (INSERT). One command per cycle, back-to-back, no bubbles.
- Storage is kept compacted: valid entries occupy slots 0..count-1, slot 0 is the head.
- INSERT: placed behind every valid entry whose price is better-or-equal (ask: ≤, bid: ≥). Equal price keeps arrival order. Entries behind it shift one slot toward the tail.
  - Not full: count+1; rsp_hit = 1.
  - Full, new price strictly better than tail: tail entry moves to reject (reject_vld_r = 1); count unchanged; rsp_hit = 1.
  - Full, otherwise: the new order itself goes to reject; rsp_hit = 0.
- CANCEL: parallel UID match. On hit, the entry is removed and later entries shift toward the head; count-1; rsp_hit = 1 with the removed entry. On miss: no state change; rsp_hit = 0; fields 0.
- POP_HEAD: removes slot 0; count-1; rsp = old head. On empty: rsp_hit = 0, no change.
- FILL_HEAD: if cmd_qty < head_qty, the head qty decrements by cmd_qty in place; rsp_qty = 0. If cmd_qty ≥ head_qty, the head is removed as in POP; rsp_qty = cmd_qty − head_qty (unfilled remainder); rsp_hit = 1. On empty: rsp_hit = 0, rsp_qty = cmd_qty.
- Illegal op: rsp_vld with rsp_hit = 0, no state change.
- Reject slot holds its value until reject_pop. If reject_pop coincides with a new reject, the new entry replaces it and reject_vld_r stays 1.
- UIDs are unique. Duplicate-UID insertion is undefined; the bench must not generate it.
- Head outputs reflect slot 0 after every update. head_vld_r = (count_r != 0).

Optional Feature:
- OB_BOOK_TABLE_MODIFY_EN defined: op 4 MODIFY sets the qty of the UID-matched entry to cmd_qty.
  - The entry keeps its position and time priority.
  - cmd_qty = 0 removes it, as CANCEL.
  - rsp_hit = hit; rsp_qty = old qty.
- Undefined: op 4 is illegal (rsp_hit = 0, no change) and no modify logic is present.

Test Plan:
- Ask side, insert prices 0x0105, 0x0100, 0x0103 (uids 1,2,3) -> head_price_r = 0x0100, uid 2; count_r = 3; order 2,3,1.
- Ask side, insert uid 4 @0x0100 after the above -> order 2,4,3,1 (time priority); POP_HEAD -> rsp uid 2; head uid 4.
- Fill N=4 with 0x0100..0x0103, insert 0x0099 -> reject uid holds the 0x0103 entry; cmd_rdy = 0 until reject_pop. Insert 0x0200 -> rejected itself, rsp_hit = 0.
- Head qty 50, FILL_HEAD qty 20 -> head_qty_r = 30, rsp_qty = 0. FILL_HEAD qty 45 -> head removed, rsp_qty = 15, count-1.
- CANCEL middle uid -> later entries shift, count-1, rsp_hit = 1. CANCEL unknown uid -> rsp_hit = 0, state unchanged. Assert rst_n mid-stream -> all outputs 0 immediately.
- OB_BOOK_TABLE_MODIFY_EN: MODIFY uid 3 qty 7 -> position kept, rsp_qty = old qty. Without the macro -> rsp_hit = 0.
